// File: rtl/gpout_bank_if.sv
// Configuration port of gpout_bank: shadow-register write fields plus the commit request.
// The master drives every field; gpout_bank only samples them on clk edges.
interface gpout_bank_if #(
    parameter int SEL_W = 6,
    parameter int DIV_W = 8
);
    logic             i_cfg_we;
    logic [3:0]       i_cfg_chan;
    logic [SEL_W-1:0] i_cfg_sel;
    logic [1:0]       i_cfg_mode;
    logic [DIV_W-1:0] i_cfg_div;
    logic             i_cfg_commit;

    modport master (
        output i_cfg_we, i_cfg_chan, i_cfg_sel, i_cfg_mode, i_cfg_div, i_cfg_commit
    );

    modport slave (
        input i_cfg_we, i_cfg_chan, i_cfg_sel, i_cfg_mode, i_cfg_div, i_cfg_commit
    );
endinterface

// File: rtl/gpout_bank.sv
// gpout_bank: bank of debug outputs, each selecting one source with a DIRECT/REG/STRETCH/CLKDIV mode.
// Optional `GPOUT_SYNC_COMMIT_EN: a pending commit applies only on an edge where i_sync=1.
module gpout_bank #(
    parameter int CHANNELS = 6,
    parameter int SEL_W    = 6,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2**SEL_W-1:0] i_src,
    gpout_bank_if.slave         cfg,
    input  logic                i_sync,
    output logic                o_cfg_pending,
    output logic [CHANNELS-1:0] o_gpout
);
    localparam logic [1:0] MODE_DIRECT  = 2'd0;
    localparam logic [1:0] MODE_REG     = 2'd1;
    localparam logic [1:0] MODE_STRETCH = 2'd2;
    localparam logic [1:0] MODE_CLKDIV  = 2'd3;

    // Config bus is strobe-only: a field set is consumed on any edge where i_cfg_we=1,
    // a commit on any edge where i_cfg_commit=1; there is no backpressure.
    logic r_pending;
    logic w_apply;

`ifdef GPOUT_SYNC_COMMIT_EN
    assign w_apply = r_pending & i_sync;
`else
    logic w_unused_sync;
    assign w_unused_sync = i_sync;
    assign w_apply       = r_pending;
`endif

    // A commit on the apply edge re-arms rather than being lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (cfg.i_cfg_commit) begin
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    assign o_cfg_pending = r_pending;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [SEL_W-1:0] r_sh_sel;
        logic [1:0]       r_sh_mode;
        logic [DIV_W-1:0] r_sh_div;
        logic [SEL_W-1:0] r_act_sel;
        logic [1:0]       r_act_mode;
        logic [DIV_W-1:0] r_act_div;
        logic [DIV_W:0]   r_cnt;
        logic             r_q;
        logic             r_s_q;
        logic             w_s;
        logic             w_rise;
        logic             w_wr;
        logic             w_out;

        // Channel numbers >= CHANNELS match no generate instance, so such writes drop out.
        assign w_wr   = cfg.i_cfg_we && (cfg.i_cfg_chan == 4'(g));
        assign w_s    = i_src[r_act_sel];
        assign w_rise = w_s & ~r_s_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_sh_sel  <= '0;
                r_sh_mode <= MODE_DIRECT;
                r_sh_div  <= '0;
            end else if (w_wr) begin
                r_sh_sel  <= cfg.i_cfg_sel;
                r_sh_mode <= cfg.i_cfg_mode;
                r_sh_div  <= cfg.i_cfg_div;
            end
        end

        // Active takes the pre-edge shadow, so a write on the apply edge waits for the next commit.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_act_sel  <= '0;
                r_act_mode <= MODE_DIRECT;
                r_act_div  <= '0;
            end else if (w_apply) begin
                r_act_sel  <= r_sh_sel;
                r_act_mode <= r_sh_mode;
                r_act_div  <= r_sh_div;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_q   <= 1'b0;
                r_s_q <= 1'b0;
            end else if (w_apply) begin
                r_cnt <= '0;
                r_q   <= 1'b0;
                r_s_q <= 1'b0;
            end else begin
                r_s_q <= w_s;
                case (r_act_mode)
                    MODE_REG: begin
                        r_q <= w_s;
                    end
                    MODE_STRETCH: begin
                        if (w_rise) begin
                            r_cnt <= {1'b0, r_act_div} + (DIV_W+1)'(1);
                        end else if (r_cnt != '0) begin
                            r_cnt <= r_cnt - (DIV_W+1)'(1);
                        end
                    end
                    MODE_CLKDIV: begin
                        if (!w_s) begin
                            r_cnt <= '0;
                            r_q   <= 1'b0;
                        end else if (r_cnt == {1'b0, r_act_div}) begin
                            r_cnt <= '0;
                            r_q   <= ~r_q;
                        end else begin
                            r_cnt <= r_cnt + (DIV_W+1)'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        always_comb begin
            w_out = w_s;
            case (r_act_mode)
                MODE_DIRECT:  w_out = w_s;
                MODE_REG:     w_out = r_q;
                MODE_STRETCH: w_out = (r_cnt != '0);
                MODE_CLKDIV:  w_out = r_q;
                default:      w_out = w_s;
            endcase
        end

        assign o_gpout[g] = w_out;
    end
endmodule

// File: tb/tb_gpout_bank.sv
// Bench for gpout_bank: directed scenarios plus random traffic, checked every cycle
// against an edge-count model of each channel mode.
module tb_gpout_bank;
    localparam int CH  = 6;
    localparam int SW  = 6;
    localparam int DW  = 8;
    localparam int NS  = 64;
    localparam int BIG = 1 << 20;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NS-1:0] src;
    logic          sync;
    logic          pend;
    logic [CH-1:0] gp;

    gpout_bank_if #(.SEL_W(SW), .DIV_W(DW)) cfg_if ();

    gpout_bank #(.CHANNELS(CH), .SEL_W(SW), .DIV_W(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_src        (src),
        .cfg          (cfg_if),
        .i_sync       (sync),
        .o_cfg_pending(pend),
        .o_gpout      (gp)
    );

    always #5 clk = ~clk;

    // Model state: configuration plus, per channel, the previous sampled source,
    // edges since the last detected rise, and length of the current high run.
    int  m_sh_sel[CH], m_sh_mode[CH], m_sh_div[CH];
    int  m_ac_sel[CH], m_ac_mode[CH], m_ac_div[CH];
    int  m_prev[CH], m_since[CH], m_run[CH];
    bit  m_pend;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    logic [CH:0] exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_sh_sel[c] = 0; m_sh_mode[c] = 0; m_sh_div[c] = 0;
            m_ac_sel[c] = 0; m_ac_mode[c] = 0; m_ac_div[c] = 0;
            m_prev[c] = 0; m_since[c] = BIG; m_run[c] = 0;
        end
        m_pend = 1'b0;
    endtask

    function automatic logic exp_bit(int c);
        logic s;
        s = src[m_ac_sel[c]];
        case (m_ac_mode[c])
            0: return s;
            1: return m_prev[c] != 0;
            2: return m_since[c] <= m_ac_div[c];
            default: return ((m_run[c] / (m_ac_div[c] + 1)) % 2) == 1;
        endcase
    endfunction

    task automatic model_edge();
        bit   apply;
        logic s;
        if (!reset_n) begin
            model_reset();
            return;
        end
`ifdef GPOUT_SYNC_COMMIT_EN
        apply = m_pend && sync;
`else
        apply = m_pend;
`endif
        for (int c = 0; c < CH; c++) begin
            s = src[m_ac_sel[c]];
            if (s && m_prev[c] == 0) m_since[c] = 0;
            else if (m_since[c] < BIG) m_since[c] = m_since[c] + 1;
            m_run[c]  = s ? m_run[c] + 1 : 0;
            m_prev[c] = s ? 1 : 0;
            if (apply) begin
                m_ac_sel[c] = m_sh_sel[c]; m_ac_mode[c] = m_sh_mode[c]; m_ac_div[c] = m_sh_div[c];
                m_prev[c] = 0; m_since[c] = BIG; m_run[c] = 0;
            end
        end
        if (cfg_if.i_cfg_we && int'(cfg_if.i_cfg_chan) < CH) begin
            m_sh_sel[cfg_if.i_cfg_chan]  = int'(cfg_if.i_cfg_sel);
            m_sh_mode[cfg_if.i_cfg_chan] = int'(cfg_if.i_cfg_mode);
            m_sh_div[cfg_if.i_cfg_chan]  = int'(cfg_if.i_cfg_div);
        end
        if (cfg_if.i_cfg_commit) m_pend = 1'b1;
        else if (apply) m_pend = 1'b0;
    endtask

    task automatic compare();
        logic [CH:0] e;
        logic [CH:0] got;
        e[CH] = m_pend;
        for (int c = 0; c < CH; c++) e[c] = exp_bit(c);
        exp_q.push_back(e);
        got = {pend, gp};
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL cycle_check cyc=%0d: got pend=%b gp=%b, expected pend=%b gp=%b",
                     cyc, got[CH], got[CH-1:0], e[CH], e[CH-1:0]);
        end
    endtask

    task automatic check_lit(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: check at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        @(negedge clk);
        compare();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cfg_wr(int chan, int sel, int mode, int div);
        cfg_if.i_cfg_we   = 1'b1;
        cfg_if.i_cfg_chan = 4'(chan);
        cfg_if.i_cfg_sel  = SW'(sel);
        cfg_if.i_cfg_mode = 2'(mode);
        cfg_if.i_cfg_div  = DW'(div);
        step();
        cfg_if.i_cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_if.i_cfg_commit = 1'b1;
        step();
        cfg_if.i_cfg_commit = 1'b0;
    endtask

    logic [7:0] cd_exp;
    logic       v;

    initial begin
        reset_n = 1'b0;
        src     = '0;
        sync    = 1'b1;
        cfg_if.i_cfg_we = 1'b0; cfg_if.i_cfg_chan = '0; cfg_if.i_cfg_sel = '0;
        cfg_if.i_cfg_mode = '0; cfg_if.i_cfg_div = '0; cfg_if.i_cfg_commit = 1'b0;
        model_reset();

        // Reset: every pin follows i_src[0] combinationally.
        for (int i = 0; i < 6; i++) begin
            src = {$urandom, $urandom};
            src[0] = i[0];
            #1;
            check_lit("reset_follow", 32'(gp), 32'({CH{src[0]}}));
            check_lit("reset_pending", 32'(pend), 32'd0);
            step();
        end
        reset_n = 1'b1;
        #1;
        check_lit("release_follow", 32'(gp), 32'({CH{src[0]}}));
        step();

        // REG on channel 2 from source 9.
        cfg_wr(2, 9, 1, 0);
        commit();
        check_lit("pending_after_commit", 32'(pend), 32'd1);
        step();
        check_lit("pending_after_apply", 32'(pend), 32'd0);
        for (int i = 0; i < 8; i++) begin
            v = 1'($urandom_range(0, 1));
            src[9] = v;
            step();
            check_lit("reg_delay", 32'(gp[2]), 32'(v));
        end
        cfg_wr(7, 3, 3, 5);
        commit();
        repeat (3) step();

        // STRETCH on channel 0, div=3: single pulse, then retrigger two cycles later.
        src[5] = 1'b0;
        cfg_wr(0, 5, 2, 3);
        commit();
        step();
        src[5] = 1'b1; step();
        check_lit("stretch_rise", 32'(gp[0]), 32'd1);
        src[5] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_lit("stretch_len", 32'(gp[0]), (i < 3) ? 32'd1 : 32'd0);
        end
        src[5] = 1'b1; step();
        src[5] = 1'b0; step();
        src[5] = 1'b1; step();
        check_lit("retrig_rise", 32'(gp[0]), 32'd1);
        src[5] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_lit("retrig_len", 32'(gp[0]), (i < 3) ? 32'd1 : 32'd0);
        end

        // CLKDIV on channel 1, div=1, constant-high source: period 4.
        src[63] = 1'b1;
        cfg_wr(1, 63, 3, 1);
        commit();
        step();
        cd_exp = 8'b01100110;
        for (int i = 0; i < 8; i++) begin
            step();
            check_lit("clkdiv_seq", 32'(gp[1]), 32'(cd_exp[i]));
        end
        src[63] = 1'b0;
        step();
        check_lit("clkdiv_drop", 32'(gp[1]), 32'd0);

        // Atomic retarget of all channels, with a write landing on the apply edge.
        src  = {$urandom, $urandom};
        sync = 1'b0;
        for (int c = 0; c < CH; c++) cfg_wr(c, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 4));
        commit();
        check_lit("atomic_pending", 32'(pend), 32'd1);
`ifdef GPOUT_SYNC_COMMIT_EN
        repeat (3) step();
        check_lit("sync_wait_pending", 32'(pend), 32'd1);
`endif
        sync = 1'b1;
        cfg_wr(0, 63, 0, 0);
        check_lit("apply_cleared", 32'(pend), 32'd0);
        repeat (4) step();
        commit();
        repeat (4) step();

        // Reset while a commit is pending.
        sync = 1'b0;
        cfg_wr(3, 12, 1, 0);
        commit();
        check_lit("midreset_pending_pre", 32'(pend), 32'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_lit("midreset_pending", 32'(pend), 32'd0);
        step();
        reset_n = 1'b1;
        sync = 1'b1;
        step();
        src[0] = ~src[0];
        #1;
        check_lit("midreset_active0", 32'(gp), 32'({CH{src[0]}}));
        step();

        // Random traffic.
        src[63] = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            src = src ^ {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            cfg_if.i_cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_if.i_cfg_chan   = 4'($urandom_range(0, 7));
            cfg_if.i_cfg_sel    = SW'($urandom_range(0, 63));
            cfg_if.i_cfg_mode   = 2'($urandom_range(0, 3));
            cfg_if.i_cfg_div    = ($urandom_range(0, 31) == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 6));
            cfg_if.i_cfg_commit = ($urandom_range(0, 15) == 0);
            sync                = ($urandom_range(0, 3) == 0);
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                model_reset();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
